// File: rtl/loop_seq_ctrl.sv
// loop_seq_ctrl: sequences one for-loop run. It steps an external j counter
// (j starts at 1), issues one body request per iteration, waits for the body's
// completion, then pulses done after `bound` iterations.
// Optional watchdog on the body wait: define LOOP_TIMEOUT_EN.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, bound        run request pulse and iteration count (IDLE only)
//   loop_en, for_valid  counter enable and counter step pulse
//   j_in, j_valid       counter value and valid
//   body_start, body_j  body request pulse and its iteration index
//   body_done           body completion pulse (sampled in WAIT only)
//   busy, done, err     activity, end-of-run pulse, sticky error
module loop_seq_ctrl #(
    parameter int jW   = 5,
    parameter int TO_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [jW-1:0] bound,
    output logic          loop_en,
    output logic          for_valid,
    input  logic [jW-1:0] j_in,
    input  logic          j_valid,
    output logic          body_start,
    output logic [jW-1:0] body_j,
    input  logic          body_done,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ISSUE,
        S_WAIT,
        S_STEP,
        S_SETTLE,
        S_FIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [jW-1:0] bound_r;
    logic [jW-1:0] body_j_r;
    logic [jW-1:0] j_exp;
    logic          err_r;
    logic          err_set;
    logic          err_clr;
    logic          run_acc;

    // After a step the counter must show exactly the previous index + 1.
    assign j_exp = body_j_r + jW'(1);

`ifdef LOOP_TIMEOUT_EN
    // The counter clears in ISSUE and reaches all-ones after 2^TO_W-1 WAIT
    // cycles; the expiry decision is taken in the WAIT cycle that lands there.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((1 << TO_W) - 2);

    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    assign to_hit = (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == S_ISSUE) begin
            to_cnt <= '0;
        end else if (state == S_WAIT) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bound_r  <= '0;
            body_j_r <= '0;
            err_r    <= 1'b0;
        end else begin
            if (run_acc) begin
                bound_r <= bound;
            end
            if (state == S_ISSUE) begin
                body_j_r <= j_in;
            end
            if (err_clr) begin
                err_r <= 1'b0;
            end else if (err_set) begin
                err_r <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        loop_en    = 1'b0;
        for_valid  = 1'b0;
        body_start = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        run_acc    = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    err_clr = 1'b1;
                    if (bound == '0) begin
                        state_nx = S_FIN;
                    end else begin
                        run_acc  = 1'b1;
                        state_nx = S_ARM;
                    end
                end
            end
            S_ARM: begin
                loop_en = 1'b1;
                if (j_valid && (j_in == jW'(1))) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                loop_en    = 1'b1;
                body_start = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT: begin
                loop_en = 1'b1;
                if (body_done) begin
                    state_nx = S_STEP;
                end
`ifdef LOOP_TIMEOUT_EN
                else if (to_hit) begin
                    err_set  = 1'b1;
                    state_nx = S_FIN;
                end
`endif
            end
            S_STEP: begin
                loop_en = 1'b1;
                // j is stable here, so the last-iteration test is exact.
                if (j_in == bound_r) begin
                    state_nx = S_FIN;
                end else begin
                    for_valid = 1'b1;
                    state_nx  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                loop_en = 1'b1;
                if (!j_valid || (j_in != j_exp)) begin
                    err_set  = 1'b1;
                    state_nx = S_FIN;
                end else begin
                    state_nx = S_ISSUE;
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign body_j = body_j_r;
    assign err    = err_r;

endmodule
